// File: rtl/comb_result_fifo.sv
// Registered result buffer for the comb_test block: a power-of-two FIFO with a
// rotate-XOR signature over accepted words and a count of delivered words.
module comb_result_fifo #(
  parameter int unsigned Size  = 1,
  parameter int unsigned Depth = 4
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    in_valid_i,
  input  logic [5*Size-1:0]       in_data_i,
  output logic                    in_ready_o,
  output logic                    out_valid_o,
  output logic [5*Size-1:0]       out_data_o,
  input  logic                    out_ready_i,
  output logic [$clog2(Depth):0]  count_o,
  output logic [5*Size-1:0]       sig_o,
  output logic [15:0]             xfer_cnt_o
);

  localparam int unsigned W     = 5 * Size;
  localparam int unsigned AddrW = $clog2(Depth);
  localparam int unsigned PtrW  = AddrW + 1;

  typedef logic [PtrW-1:0] ptr_t;

  logic [W-1:0] mem_q [Depth];
  ptr_t         wr_ptr_q, wr_ptr_d;
  ptr_t         rd_ptr_q, rd_ptr_d;
  logic [W-1:0] sig_q, sig_d;
  logic [15:0]  xfer_cnt_q, xfer_cnt_d;
  logic         full, empty, push, pop;

  // Extra pointer MSB distinguishes full from empty when the address bits match.
  always_comb begin
    empty = (wr_ptr_q == rd_ptr_q);
    full  = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
            (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
    push  = in_valid_i && !full;
    pop   = out_ready_i && !empty;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    sig_d      = sig_q;
    xfer_cnt_d = xfer_cnt_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + ptr_t'(1);
      sig_d    = {sig_q[W-2:0], sig_q[W-1]} ^ in_data_i;
    end
    if (pop) begin
      rd_ptr_d   = rd_ptr_q + ptr_t'(1);
      xfer_cnt_d = xfer_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      sig_q      <= '0;
      xfer_cnt_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      sig_q      <= sig_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  // Storage is deliberately left uncleared; only the pointers define contents.
  always_ff @(posedge clk_i) begin
    if (push && !reset_i) begin
      mem_q[wr_ptr_q[AddrW-1:0]] <= in_data_i;
    end
  end

  assign in_ready_o  = !full;
  assign out_valid_o = !empty;
  assign out_data_o  = mem_q[rd_ptr_q[AddrW-1:0]];
  assign count_o     = wr_ptr_q - rd_ptr_q;
  assign sig_o       = sig_q;
  assign xfer_cnt_o  = xfer_cnt_q;

endmodule

// File: tb/tb_comb_result_fifo.sv
// Scoreboard bench for comb_result_fifo at Size=2 (W=10), Depth=4.
module tb_comb_result_fifo;

  localparam int unsigned Size  = 2;
  localparam int unsigned Depth = 4;
  localparam int unsigned W     = 5 * Size;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [2:0]   count;
  logic [W-1:0] sig;
  logic [15:0]  xfer_cnt;

  int n_tests;
  int n_fail;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] m_sig;
  logic [15:0]  m_xfer;

  comb_result_fifo #(
    .Size (Size),
    .Depth(Depth)
  ) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .in_valid_i (in_valid),
    .in_data_i  (in_data),
    .in_ready_o (in_ready),
    .out_valid_o(out_valid),
    .out_data_o (out_data),
    .out_ready_i(out_ready),
    .count_o    (count),
    .sig_o      (sig),
    .xfer_cnt_o (xfer_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] rotl(input logic [W-1:0] s);
    return {s[W-2:0], s[W-1]};
  endfunction

  // Advance one clock edge, updating the model from the handshakes the model predicts.
  task automatic cycle(output bit pushed, output bit popped, output logic [W-1:0] got,
                       output logic [W-1:0] want);
    bit push, pop;
    push   = in_valid && (exp_q.size() < Depth);
    pop    = out_ready && (exp_q.size() > 0);
    got    = out_data;
    want   = '0;
    pushed = 1'b0;
    popped = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_sig  = '0;
      m_xfer = '0;
    end else begin
      if (pop) begin
        want   = exp_q.pop_front();
        m_xfer = m_xfer + 16'd1;
        popped = 1'b1;
      end
      if (push) begin
        exp_q.push_back(in_data);
        m_sig  = rotl(m_sig) ^ in_data;
        pushed = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    bit pu, po;
    logic [W-1:0] g, w;
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    cycle(pu, po, g, w);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    bit pu, po;
    logic [W-1:0] g, w;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      n_tests++;
      if (count !== 3'd0 || in_ready !== 1'b1 || out_valid !== 1'b0 || sig !== '0 ||
          xfer_cnt !== 16'd0) begin
        n_fail++;
        $display("FAIL reset_idle cyc %0d: got count=%0d rdy=%b vld=%b sig=%h xfer=%0d, want 0 1 0 0 0",
                 i, count, in_ready, out_valid, sig, xfer_cnt);
      end
      cycle(pu, po, g, w);
    end
  endtask

  task automatic test_single();
    bit pu, po;
    logic [W-1:0] g, w, sig_hold;
    do_reset();
    in_valid = 1'b1;
    in_data  = 10'h2B5;
    cycle(pu, po, g, w);
    in_valid = 1'b0;
    in_data  = 'x;
    n_tests++;
    if (out_valid !== 1'b1 || out_data !== 10'h2B5 || count !== 3'd1 || sig !== 10'h2B5) begin
      n_fail++;
      $display("FAIL single_push: got vld=%b data=%h count=%0d sig=%h, want 1 2b5 1 2b5",
               out_valid, out_data, count, sig);
    end
    // Idle with X on in_data: signature must stay put.
    sig_hold = m_sig;
    cycle(pu, po, g, w);
    cycle(pu, po, g, w);
    n_tests++;
    if (sig !== sig_hold || count !== 3'd1) begin
      n_fail++;
      $display("FAIL idle_x_data: got sig=%h count=%0d, want %h 1", sig, count, sig_hold);
    end
    out_ready = 1'b1;
    cycle(pu, po, g, w);
    out_ready = 1'b0;
    n_tests++;
    if (!po || g !== w || xfer_cnt !== 16'd1 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL single_pop: got popped=%b data=%h xfer=%0d count=%0d, want 1 %h 1 0",
               po, g, xfer_cnt, count, w);
    end
  endtask

  task automatic test_fill();
    bit pu, po;
    logic [W-1:0] g, w;
    logic [W-1:0] words [4];
    int pops;
    words[0] = 10'h001;
    words[1] = 10'h002;
    words[2] = 10'h004;
    words[3] = 10'h008;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = words[i];
      cycle(pu, po, g, w);
    end
    in_data = 10'h3FF;
    cycle(pu, po, g, w);
    cycle(pu, po, g, w);
    n_tests++;
    if (count !== 3'd4 || in_ready !== 1'b0 || sig !== m_sig) begin
      n_fail++;
      $display("FAIL fill_full: got count=%0d rdy=%b sig=%h, want 4 0 %h",
               count, in_ready, sig, m_sig);
    end
    out_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 20 && pops < 5; i++) begin
      cycle(pu, po, g, w);
      if (pu) in_valid = 1'b0;
      if (po) begin
        pops++;
        n_tests++;
        if (g !== w) begin
          n_fail++;
          $display("FAIL fill_drain #%0d: got %h, want %h", pops, g, w);
        end
      end
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    n_tests++;
    if (pops != 5 || count !== 3'd0 || xfer_cnt !== m_xfer || sig !== m_sig) begin
      n_fail++;
      $display("FAIL fill_end: got pops=%0d count=%0d xfer=%0d sig=%h, want 5 0 %0d %h",
               pops, count, xfer_cnt, sig, m_xfer, m_sig);
    end
  endtask

  task automatic test_full_simul();
    bit pu, po;
    logic [W-1:0] g, w;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data = W'(10'h100 + i);
      cycle(pu, po, g, w);
    end
    in_data   = 10'h155;
    out_ready = 1'b1;
    cycle(pu, po, g, w);
    n_tests++;
    if (count !== 3'd3 || in_ready !== 1'b1 || g !== w || pu) begin
      n_fail++;
      $display("FAIL full_simul: got count=%0d rdy=%b data=%h, want 3 1 %h", count, in_ready,
               g, w);
    end
    cycle(pu, po, g, w);
    n_tests++;
    if (count !== 3'd3 || g !== w || sig !== m_sig) begin
      n_fail++;
      $display("FAIL both_mid: got count=%0d data=%h sig=%h, want 3 %h %h", count, g, sig, w,
               m_sig);
    end
    in_valid = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      cycle(pu, po, g, w);
      if (po) begin
        n_tests++;
        if (g !== w) begin
          n_fail++;
          $display("FAIL simul_drain: got %h, want %h", g, w);
        end
      end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bit pu, po;
    logic [W-1:0] g, w;
    int sent, pops, errs;
    do_reset();
    sent = 0;
    pops = 0;
    errs = 0;
    in_valid  = 1'b1;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 300 && pops < 40; i++) begin
      cycle(pu, po, g, w);
      if (pu) sent++;
      in_data  = W'(sent);
      in_valid = (sent < 40);
      if (po) begin
        pops++;
        if (g !== w || g !== W'(pops - 1)) begin
          errs++;
          n_fail++;
          $display("FAIL wrap_order #%0d: got %h, want %h", pops - 1, g, W'(pops - 1));
        end
      end
      out_ready = ~out_ready;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    n_tests++;
    if (pops != 40 || xfer_cnt !== 16'd40 || count !== 3'd0) begin
      n_fail++;
      $display("FAIL wrap_end: got pops=%0d xfer=%0d count=%0d, want 40 40 0", pops, xfer_cnt,
               count);
    end
    n_tests++;
    if (sig !== m_sig) begin
      n_fail++;
      $display("FAIL wrap_sig: got %h, want %h", sig, m_sig);
    end
  endtask

  task automatic test_reset_mid();
    bit pu, po;
    logic [W-1:0] g, w;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = W'(10'h0A0 + i);
      cycle(pu, po, g, w);
    end
    out_ready = 1'b1;
    out_ready = 1'b0;
    n_tests++;
    if (count !== 3'd3) begin
      n_fail++;
      $display("FAIL mid_pre: got count=%0d, want 3", count);
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 10'h3C3;
    cycle(pu, po, g, w);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_tests++;
      if (count !== 3'd0 || sig !== '0 || xfer_cnt !== 16'd0 || out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid cyc %0d: got count=%0d sig=%h xfer=%0d vld=%b, want 0 0 0 0",
                 i, count, sig, xfer_cnt, out_valid);
      end
      cycle(pu, po, g, w);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    m_sig     = '0;
    m_xfer    = '0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_full_simul();
    test_wrap();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
